// File: rtl/alu_add_seq.sv
// Multi-cycle 64-bit ALU (add/sub/and/xor) computing SLICE_W bits per clock.
// Optional condition-code register {zf,sf,of} is built when ALU_CC_REG_EN is defined.
module alu_add_seq #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
`ifdef ALU_CC_REG_EN
  input  logic        set_cc,
  output logic [2:0]  cc,
`endif
  output logic        ready,
  output logic        done,
  output logic [63:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        zf,
  output logic        sf
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_reg, state_next;
  logic [63:0]   a_reg, b_reg, acc_reg;
  logic [1:0]    op_reg;
  logic [KW-1:0] k_reg;
  logic          cin_reg;
  logic [63:0]   result_reg;
  logic          carry_reg, overflow_reg, zf_reg, sf_reg;

  logic [SLICE_W-1:0] a_sl, b_sl, slice;
  logic [SLICE_W:0]   sum;
  logic [63:0]        full;
  logic               cout, c_into_msb, arith, last_slice, ovf_full;

  // One slice of the datapath; sub is a + ~b with the carry-in seeded to 1.
  always_comb begin
    a_sl = a_reg[k_reg*SLICE_W +: SLICE_W];
    b_sl = b_reg[k_reg*SLICE_W +: SLICE_W];
    if (op_reg == 2'b01) begin
      b_sl = ~b_sl;
    end
    sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, cin_reg};
    case (op_reg)
      2'b10:   slice = a_sl & b_sl;
      2'b11:   slice = a_sl ^ b_sl;
      default: slice = sum[SLICE_W-1:0];
    endcase
    cout       = sum[SLICE_W];
    c_into_msb = a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ sum[SLICE_W-1];
    arith      = ~op_reg[1];
    ovf_full   = arith & (c_into_msb ^ cout);
    last_slice = (k_reg == K_LAST);
    full       = acc_reg;
    full[k_reg*SLICE_W +: SLICE_W] = slice;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      op_reg       <= '0;
      k_reg        <= '0;
      cin_reg      <= 1'b0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zf_reg       <= 1'b0;
      sf_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        a_reg   <= a;
        b_reg   <= b;
        op_reg  <= op;
        k_reg   <= '0;
        cin_reg <= (op == 2'b01);
      end else if (state_reg == CALC) begin
        acc_reg <= full;
        cin_reg <= cout;
        k_reg   <= k_reg + 1'b1;
        // Visible outputs change only once the whole word is assembled.
        if (last_slice) begin
          result_reg   <= full;
          carry_reg    <= arith & cout;
          overflow_reg <= ovf_full;
          zf_reg       <= (full == 64'd0);
          sf_reg       <= full[63];
        end
      end
    end
  end

`ifdef ALU_CC_REG_EN
  logic [2:0] cc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_reg <= 3'b000;
    end else if (state_reg == CALC && last_slice && set_cc) begin
      cc_reg <= {(full == 64'd0), full[63], ovf_full};
    end
  end

  assign cc = cc_reg;
`endif

  assign result   = result_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign zf       = zf_reg;
  assign sf       = sf_reg;

endmodule

// File: doc/alu_add_seq.md
ALU_ADD_SEQ -- requirements
Module: alu_add_seq

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 16, giving the adder slice width per cycle; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL derive NSLICE = 64/SLICE_W, the number of compute cycles per operation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request.
REQ-006 The block SHALL have port op, input, 2 bits: 00 add, 01 sub (a-b), 10 and, 11 xor.
REQ-007 The block SHALL have ports a and b, inputs, 64 bits each, signed: the operands.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a start is accepted.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 64 bits, signed: the operation result.
REQ-011 The block SHALL have ports carry, overflow, zf and sf, outputs, 1 bit each: status of the last completed operation.
REQ-012 The block SHALL have ports set_cc (input, 1 bit) and cc (output, 3 bits, {zf,sf,of}) only when ALU_CC_REG_EN is defined.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 ready SHALL be 1 in IDLE and 0 in every other state.
REQ-015 An edge in IDLE with start=1 SHALL latch a, b and op, clear the slice counter, set carry-in to op==01, and enter CALC.
REQ-016 start SHALL be ignored in CALC and DONE, and latched operands SHALL NOT change during those states.
REQ-017 Each CALC edge SHALL compute slice k = bits [k*SLICE_W +: SLICE_W] of result, store the slice carry-out as the next carry-in, and increment k.
REQ-018 Add SHALL compute a+b with cin=0; sub SHALL compute a+~b with cin=1; and/xor SHALL be bitwise with no carry chain.
REQ-019 The edge that processes slice NSLICE-1 SHALL enter DONE, so done is high exactly NSLICE+1 edges after the accepting edge, for one cycle.
REQ-020 The next edge SHALL return from DONE to IDLE; a start present in DONE is not accepted.
REQ-021 For add/sub, carry SHALL be the carry out of bit 63 (sub: carry=1 means no borrow), and overflow SHALL be the carry into bit 63 XOR the carry out of bit 63.
REQ-022 For and/xor, carry and overflow SHALL be 0.
REQ-023 zf SHALL equal (result==0) and sf SHALL equal result[63].
REQ-024 result, carry, overflow, zf and sf SHALL update only on the edge entering DONE and hold until the next DONE.
REQ-025 Intermediate partial results SHALL NOT be visible on result.
REQ-026 With SLICE_W=64, exactly one CALC cycle SHALL occur.

Reset
REQ-027 rst=1 SHALL immediately force the state to IDLE, the slice counter to 0, result to 0, carry, overflow, zf, sf and done to 0, and ready to 1.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse, and the outputs SHALL show the reset values.
REQ-029 On the first edge after rst deasserts with start=1, the block SHALL accept the request.

Configuration
REQ-030 When ALU_CC_REG_EN is defined, cc SHALL be a register, reset to 3'b000, and loaded with {zf,sf,overflow} on the edge entering DONE when set_cc=1 on that edge; otherwise cc holds.
REQ-031 When ALU_CC_REG_EN is undefined, set_cc and cc SHALL be absent and no cc register SHALL be built; all other behaviour is identical.

Verification
REQ-032 Add a=64'h7FFFFFFFFFFFFFFF, b=1 -> done 5 cycles after accept; result=64'h8000000000000000, overflow=1, carry=0, sf=1, zf=0.
REQ-033 Add a=64'hFFFFFFFFFFFFFFFF, b=1 -> result=0, carry=1, overflow=0, zf=1; the carry ripples through all 4 slices.
REQ-034 Sub a=5, b=5 -> result=0, zf=1, carry=1; sub a=3, b=5 -> result=64'hFFFFFFFFFFFFFFFE, sf=1, carry=0.
REQ-035 Start held high through CALC/DONE with changing a/b -> only the first operation completes, and ready pulses back high after done.
REQ-036 rst asserted at the 2nd CALC cycle of a=1,b=1 -> no done pulse, result=0, ready=1; a new and a=64'hF0F0,b=64'hFF00 -> result=64'hF000, carry=0.
REQ-037 With ALU_CC_REG_EN: sub 5-5 with set_cc=1 -> cc=3'b100; a following add 1+1 with set_cc=0 -> cc stays 3'b100.
